if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch sequencer for the IF stage. It consumes the current fetch address from the PC register and returns `pc_enable` to it. It issues reads on the instruction bus and presents instruction/PC pairs to the ID stage through a one-entry output register plus a one-entry skid buffer. It also discards in-flight fetches on redirect (branch, exception or debug) and reports misaligned fetch addresses.

## Interface
- `NOP_INSTR`, 32'h00000000: value driven on `id_instr` for faulted or empty slots.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `pc_address`  in  32  current PC. Stable until this block pulses `pc_enable` or a redirect occurs.
- `pc_enable`  out  1  combinational. Advances the PC by 4 at this edge.
- `flush`  in  1  the PC loads a non-sequential value at this edge. Any fetch in flight is dropped.
- `stall_id`  in  1  ID cannot accept a new instruction this cycle.
- `ibus_read`  out  1  registered read request.
- `ibus_address`  out  32  registered read address. Held stable while `ibus_read`=1.
- `ibus_ready`  in  1  one-cycle pulse; `ibus_rddata` is valid in that cycle.
- `ibus_rddata`  in  32  read data.
- `id_valid`  out  1  ID slot holds an instruction.
- `id_pc`  out  32  address of `id_instr`.
- `id_instr`  out  32  fetched instruction.
- `id_addr_err`  out  1  slot carries an address-error fault, not an instruction.

## Operation
- `out_free` = `!id_valid || !stall_id`.
- **States:** IDLE, WAIT, HOLD, DRAIN, FAULT.
- **IDLE** (entered from reset):
  - If `flush`=1: stay in IDLE.
  - If `pc_address[1:0]`≠0: go to FAULT; no bus request is issued.
  - Otherwise: `ibus_address`<=`pc_address`, `ibus_read`<=1, go to WAIT.
- **WAIT** (`ibus_read`=1):
  - `ibus_ready` && `flush`: drop the data, `ibus_read`<=0, go to IDLE.
  - `ibus_ready` && `out_free`: `id_pc`<=`ibus_address`, `id_instr`<=`ibus_rddata`, `id_valid`<=1, `id_addr_err`<=0. Assert `pc_enable`. `ibus_address`<=`ibus_address`+4 and stay in WAIT (back-to-back fetch).
  - `ibus_ready` && !`out_free`: skid<=`ibus_rddata`, `ibus_read`<=0, go to HOLD.
  - !`ibus_ready` && `flush`: go to DRAIN. `ibus_read` and `ibus_address` are unchanged, because the bus cannot cancel a request.
- **HOLD:**
  - `flush`: drop the skid entry, go to IDLE.
  - Else if `out_free`: the ID slot takes {`ibus_address`, skid}. Assert `pc_enable`, `ibus_address`<=+4, `ibus_read`<=1, go to WAIT.
- **DRAIN:** keep requesting the old address. On `ibus_ready`, discard the data, `ibus_read`<=0, go to IDLE. A `flush` while in DRAIN is absorbed; the state stays DRAIN.
- **FAULT:**
  - When `out_free`: load the slot with `id_pc`=`pc_address`, `id_instr`=`NOP_INSTR`, `id_addr_err`=1, `id_valid`=1.
  - Then remain in FAULT, with the slot loaded at most once and no `pc_enable`, until `flush`. On `flush`, go to IDLE.
- `pc_enable` is asserted only in WAIT or HOLD, as specified above; it is 0 in all other states.
- **ID slot:**
  - `flush` clears `id_valid` and `id_addr_err` at the edge. Flush has priority over loading.
  - If the slot is consumed (`id_valid` && !`stall_id`) and nothing new is loaded, `id_valid`<=0.
  - `id_pc` and `id_instr` are held when not loading.
- Address arithmetic is 32-bit modulo; 32'hfffffffc + 4 wraps to 0.
- Delay-slot ordering is upstream's responsibility. `flush` is raised only once the delay slot has been accepted.

## Timing
- **Reset values:** state IDLE, `ibus_read`=0, `ibus_address`=0, `id_valid`=0, `id_pc`=0, `id_instr`=`NOP_INSTR`, `id_addr_err`=0, skid=0.
- Reset mid-transaction abandons the request. The bus slave shares `rst`.
- **Latency:** for a zero-wait bus, the first request appears 1 cycle after reset release. `ibus_ready` in cycle N gives `id_valid` in N+1.
- **Throughput:** one instruction per cycle with zero-wait memory and no stall.
- `pc_enable` is never asserted in the same cycle as `flush`.
- `ibus_address` and `ibus_read` change only on a clock edge where `ibus_ready`=1, or where `ibus_read`=0.

## Test plan
- **Streaming fetch:** release reset with PC=32'hbfc00000 and a zero-wait bus. Required: `ibus_address` steps 32'hbfc00000, 32'hbfc00004, 32'hbfc00008; `id_valid` is continuous from cycle 2; `pc_enable`=1 every cycle.
- **ID stall:** hold `stall_id`=1 for 3 cycles with slot full, while `ibus_ready` returns 32'h24020001. Required: the block enters HOLD with `ibus_read`=0 and `pc_enable`=0. One cycle after `stall_id` falls, `id_instr`=32'h24020001 with the correct `id_pc`.
- **Flush during a 4-wait-state read:** pulse `flush` in wait cycle 1 and move PC to 32'h80000180. Required: DRAIN keeps the old `ibus_address`; the old data is discarded with `id_valid`=0; the next request is to 32'h80000180.
- **Flush coinciding with `ibus_ready`:** Required: the data is dropped, `pc_enable`=0, `id_valid` is cleared, and the block re-requests from the new PC after one IDLE cycle.
- **Misaligned PC 32'h00400002:** Required: no bus request; `id_valid`=1, `id_addr_err`=1, `id_instr`=0, `pc_enable`=0 until `flush`.
- **Async `rst`** mid-WAIT: Required: all outputs immediately return to their reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction bus bundle between the fetch sequencer and memory.
// The master issues reads; the slave returns a one-cycle ready pulse.
interface if_fetch_if;
   logic        ibus_read;
   logic [31:0] ibus_address;
   logic        ibus_ready;
   logic [31:0] ibus_rddata;

   modport master (
      output ibus_read,
      output ibus_address,
      input  ibus_ready,
      input  ibus_rddata
   );

   modport slave (
      input  ibus_read,
      input  ibus_address,
      output ibus_ready,
      output ibus_rddata
   );
endinterface

// File: rtl/if_fetch.sv
// IF stage fetch sequencer: instruction bus reads, one-entry ID slot,
// one-entry skid buffer, redirect draining and misaligned-PC faults.
module if_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_address,
   output logic        pc_enable,
   input  logic        flush,
   input  logic        stall_id,
   if_fetch_if.master  ibus,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_addr_err
);
   localparam logic [31:0] NOP_INSTR = 32'h00000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD,
      S_DRAIN,
      S_FAULT
   } state_t;

   state_t      state_q, state_d;
   logic        read_q, read_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] skid_q, skid_d;
   logic        fdone_q, fdone_d;
   logic        valid_q, valid_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] instr_q, instr_d;
   logic        err_q, err_d;

   logic        out_free;
   logic        load;
   logic [31:0] ld_pc;
   logic [31:0] ld_instr;
   logic        ld_err;

   assign out_free = !valid_q || !stall_id;

   // Next-state, bus request and ID slot update logic.
   always_comb begin
      state_d   = state_q;
      read_d    = read_q;
      addr_d    = addr_q;
      skid_d    = skid_q;
      fdone_d   = fdone_q;
      valid_d   = valid_q;
      ipc_d     = ipc_q;
      instr_d   = instr_q;
      err_d     = err_q;
      pc_enable = 1'b0;
      load      = 1'b0;
      ld_pc     = addr_q;
      ld_instr  = skid_q;
      ld_err    = 1'b0;

      case (state_q)
         S_IDLE: begin
            fdone_d = 1'b0;
            if (flush) begin
               state_d = S_IDLE;
            end else if (pc_address[1:0] != 2'b00) begin
               state_d = S_FAULT;
            end else begin
               addr_d  = pc_address;
               read_d  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ibus.ibus_ready && flush) begin
               read_d  = 1'b0;
               state_d = S_IDLE;
            end else if (ibus.ibus_ready && out_free) begin
               load      = 1'b1;
               ld_instr  = ibus.ibus_rddata;
               pc_enable = 1'b1;
               addr_d    = addr_q + 32'd4;
            end else if (ibus.ibus_ready) begin
               skid_d  = ibus.ibus_rddata;
               read_d  = 1'b0;
               state_d = S_HOLD;
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end
         S_HOLD: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (out_free) begin
               load      = 1'b1;
               pc_enable = 1'b1;
               addr_d    = addr_q + 32'd4;
               read_d    = 1'b1;
               state_d   = S_WAIT;
            end
         end
         S_DRAIN: begin
            // The bus cannot cancel, so the stale beat is swallowed here.
            if (ibus.ibus_ready) begin
               read_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_FAULT: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (out_free && !fdone_q) begin
               load     = 1'b1;
               ld_pc    = pc_address;
               ld_instr = NOP_INSTR;
               ld_err   = 1'b1;
               fdone_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         ipc_d   = ld_pc;
         instr_d = ld_instr;
         err_d   = ld_err;
      end else if (valid_q && !stall_id) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         read_q  <= 1'b0;
         addr_q  <= 32'd0;
         skid_q  <= 32'd0;
         fdone_q <= 1'b0;
         valid_q <= 1'b0;
         ipc_q   <= 32'd0;
         instr_q <= NOP_INSTR;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         skid_q  <= skid_d;
         fdone_q <= fdone_d;
         valid_q <= valid_d;
         ipc_q   <= ipc_d;
         instr_q <= instr_d;
         err_q   <= err_d;
      end
   end

   assign ibus.ibus_read    = read_q;
   assign ibus.ibus_address = addr_q;
   assign id_valid          = valid_q;
   assign id_pc             = ipc_q;
   assign id_instr          = instr_q;
   assign id_addr_err       = err_q;
endmodule

// File: tb/tb_if_fetch.sv
// Directed vector bench for if_fetch: per-cycle input/expected table
// plus a hand-written asynchronous reset sequence.
module tb_if_fetch;
   logic        clk;
   logic        rst;
   logic [31:0] pc_address;
   logic        pc_enable;
   logic        flush;
   logic        stall_id;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_addr_err;

   if_fetch_if bus ();

   if_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .pc_address  (pc_address),
      .pc_enable   (pc_enable),
      .flush       (flush),
      .stall_id    (stall_id),
      .ibus        (bus),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_instr    (id_instr),
      .id_addr_err (id_addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        fl;
      logic        st;
      logic        rdy;
      logic [31:0] dat;
      logic        pe;
      logic        rd;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ipc;
      logic [31:0] ins;
      logic        err;
   } vec_t;

   localparam int NV = 33;
   vec_t tbl [NV];

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] D0 = 32'h3c080001;
   localparam logic [31:0] D1 = 32'h35080002;
   localparam logic [31:0] D2 = 32'h01094821;
   localparam logic [31:0] DS = 32'h24020001;
   localparam logic [31:0] D3 = 32'hafbf0010;
   localparam logic [31:0] D4 = 32'h401a6800;
   localparam logic [31:0] D6 = 32'h8fa40000;

   function automatic vec_t mk(
      input logic [31:0] pc, input logic fl, input logic st,
      input logic rdy, input logic [31:0] dat,
      input logic pe, input logic rd, input logic [31:0] addr,
      input logic v, input logic [31:0] ipc, input logic [31:0] ins,
      input logic err);
      vec_t r;
      r.pc = pc;  r.fl = fl;   r.st = st;     r.rdy = rdy;
      r.dat = dat; r.pe = pe;  r.rd = rd;     r.addr = addr;
      r.v = v;    r.ipc = ipc; r.ins = ins;   r.err = err;
      return r;
   endfunction

   task automatic chk(
      input string nm, input logic pe, input logic rd,
      input logic [31:0] addr, input logic v, input logic [31:0] ipc,
      input logic [31:0] ins, input logic err);
      n_tests++;
      if (pc_enable !== pe || bus.ibus_read !== rd ||
          bus.ibus_address !== addr || id_valid !== v ||
          id_pc !== ipc || id_instr !== ins || id_addr_err !== err) begin
         n_fail++;
         $display("FAIL %s: got pe=%b rd=%b addr=%h v=%b pc=%h ins=%h err=%b; want pe=%b rd=%b addr=%h v=%b pc=%h ins=%h err=%b",
                  nm, pc_enable, bus.ibus_read, bus.ibus_address,
                  id_valid, id_pc, id_instr, id_addr_err,
                  pe, rd, addr, v, ipc, ins, err);
      end
   endtask

   task automatic run_row(input int i);
      pc_address       = tbl[i].pc;
      flush            = tbl[i].fl;
      stall_id         = tbl[i].st;
      bus.ibus_ready   = tbl[i].rdy;
      bus.ibus_rddata  = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("row%0d", i), tbl[i].pe, tbl[i].rd, tbl[i].addr,
          tbl[i].v, tbl[i].ipc, tbl[i].ins, tbl[i].err);
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             pc          fl st rdy dat           pe rd addr         v  id_pc        instr err
      tbl[0]  = mk(32'hbfc00000, 0, 0, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0,       32'h0, 0);
      tbl[1]  = mk(32'hbfc00000, 0, 0, 1, D0,            1, 1, 32'hbfc00000, 0, 32'h0,       32'h0, 0);
      tbl[2]  = mk(32'hbfc00004, 0, 0, 1, D1,            1, 1, 32'hbfc00004, 1, 32'hbfc00000, D0,   0);
      tbl[3]  = mk(32'hbfc00008, 0, 0, 1, D2,            1, 1, 32'hbfc00008, 1, 32'hbfc00004, D1,   0);
      tbl[4]  = mk(32'hbfc0000c, 0, 1, 1, DS,            0, 1, 32'hbfc0000c, 1, 32'hbfc00008, D2,   0);
      tbl[5]  = mk(32'hbfc0000c, 0, 1, 0, 32'h0,         0, 0, 32'hbfc0000c, 1, 32'hbfc00008, D2,   0);
      tbl[6]  = mk(32'hbfc0000c, 0, 1, 0, 32'h0,         0, 0, 32'hbfc0000c, 1, 32'hbfc00008, D2,   0);
      tbl[7]  = mk(32'hbfc0000c, 0, 0, 0, 32'h0,         1, 0, 32'hbfc0000c, 1, 32'hbfc00008, D2,   0);
      tbl[8]  = mk(32'hbfc00010, 0, 0, 0, 32'h0,         0, 1, 32'hbfc00010, 1, 32'hbfc0000c, DS,   0);
      tbl[9]  = mk(32'hbfc00010, 0, 0, 1, D3,            1, 1, 32'hbfc00010, 0, 32'hbfc0000c, DS,   0);
      tbl[10] = mk(32'hbfc00014, 0, 0, 0, 32'h0,         0, 1, 32'hbfc00014, 1, 32'hbfc00010, D3,   0);
      tbl[11] = mk(32'hbfc00014, 1, 0, 0, 32'h0,         0, 1, 32'hbfc00014, 0, 32'hbfc00010, D3,   0);
      tbl[12] = mk(32'h80000180, 0, 0, 0, 32'h0,         0, 1, 32'hbfc00014, 0, 32'hbfc00010, D3,   0);
      tbl[13] = mk(32'h80000180, 0, 0, 0, 32'h0,         0, 1, 32'hbfc00014, 0, 32'hbfc00010, D3,   0);
      tbl[14] = mk(32'h80000180, 0, 0, 1, 32'hdeadbeef,  0, 1, 32'hbfc00014, 0, 32'hbfc00010, D3,   0);
      tbl[15] = mk(32'h80000180, 0, 0, 0, 32'h0,         0, 0, 32'hbfc00014, 0, 32'hbfc00010, D3,   0);
      tbl[16] = mk(32'h80000180, 0, 0, 1, D4,            1, 1, 32'h80000180, 0, 32'hbfc00010, D3,   0);
      tbl[17] = mk(32'h80000184, 1, 0, 1, 32'h11111111,  0, 1, 32'h80000184, 1, 32'h80000180, D4,   0);
      tbl[18] = mk(32'h00001000, 0, 0, 0, 32'h0,         0, 0, 32'h80000184, 0, 32'h80000180, D4,   0);
      tbl[19] = mk(32'h00001000, 0, 0, 1, D6,            1, 1, 32'h00001000, 0, 32'h80000180, D4,   0);
      tbl[20] = mk(32'h00001004, 1, 0, 0, 32'h0,         0, 1, 32'h00001004, 1, 32'h00001000, D6,   0);
      tbl[21] = mk(32'h00400002, 0, 0, 1, 32'h22222222,  0, 1, 32'h00001004, 0, 32'h00001000, D6,   0);
      tbl[22] = mk(32'h00400002, 0, 1, 0, 32'h0,         0, 0, 32'h00001004, 0, 32'h00001000, D6,   0);
      tbl[23] = mk(32'h00400002, 0, 1, 0, 32'h0,         0, 0, 32'h00001004, 0, 32'h00001000, D6,   0);
      tbl[24] = mk(32'h00400002, 0, 1, 0, 32'h0,         0, 0, 32'h00001004, 1, 32'h00400002, 32'h0, 1);
      tbl[25] = mk(32'h00400002, 0, 0, 0, 32'h0,         0, 0, 32'h00001004, 1, 32'h00400002, 32'h0, 1);
      tbl[26] = mk(32'h00400002, 0, 0, 0, 32'h0,         0, 0, 32'h00001004, 0, 32'h00400002, 32'h0, 1);
      tbl[27] = mk(32'h00400002, 1, 0, 0, 32'h0,         0, 0, 32'h00001004, 0, 32'h00400002, 32'h0, 1);
      tbl[28] = mk(32'h00002000, 0, 0, 0, 32'h0,         0, 0, 32'h00001004, 0, 32'h00400002, 32'h0, 0);
      tbl[29] = mk(32'h00002000, 0, 0, 0, 32'h0,         0, 1, 32'h00002000, 0, 32'h00400002, 32'h0, 0);
      tbl[30] = mk(32'hfffffffc, 0, 0, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0,       32'h0, 0);
      tbl[31] = mk(32'hfffffffc, 0, 0, 1, 32'h0000a5a5,  1, 1, 32'hfffffffc, 0, 32'h0,       32'h0, 0);
      tbl[32] = mk(32'h00000000, 0, 0, 0, 32'h0,         0, 1, 32'h00000000, 1, 32'hfffffffc, 32'h0000a5a5, 0);

      rst             = 1'b1;
      pc_address      = 32'hbfc00000;
      flush           = 1'b0;
      stall_id        = 1'b0;
      bus.ibus_ready  = 1'b0;
      bus.ibus_rddata = 32'h0;
      #2;
      chk("reset", 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 30; i++) run_row(i);

      // Async reset while a read is outstanding, checked before any edge.
      bus.ibus_ready = 1'b0;
      pc_address     = 32'hfffffffc;
      rst            = 1'b1;
      #1;
      chk("async_rst", 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 30; i < NV; i++) run_row(i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish, want finish before 20000");
      $fatal(1);
   end
endmodule
